// File: rtl/alu_bist_pkg.sv
// Shared types and constants for the ALU built-in self-test controller.
package alu_bist_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CAPTURE = 2'd2,
    CHECK   = 2'd3
  } bist_state_t;

  // Feedback taps shared by the operand LFSR and the response MISR.
  localparam logic [31:0] BIST_POLY = 32'h0040_0007;

  localparam int CNT_W        = 4;
  localparam int SHAMT_W      = 5;
  localparam int NUM_DIRECTED = 4;

  typedef struct packed {
    logic [31:0]        op1;
    logic [31:0]        op2;
    logic [SHAMT_W-1:0] shamt;
  } dir_pat_t;

  // Corner-case operand pairs applied ahead of the random patterns when the
  // directed phase is built in.
  localparam dir_pat_t DIRECTED_PATS [NUM_DIRECTED] = '{
    '{op1: 32'h0000_0000, op2: 32'h0000_0000, shamt: 5'd0},
    '{op1: 32'hFFFF_FFFF, op2: 32'h0000_0001, shamt: 5'd31},
    '{op1: 32'h7FFF_FFFF, op2: 32'h0000_0001, shamt: 5'd1},
    '{op1: 32'h0000_0003, op2: 32'h0000_0003, shamt: 5'd1}
  };

  // One Galois left-shift step.
  function automatic logic [31:0] galois_step(input logic [31:0] v);
    return (v << 1) ^ (v[31] ? BIST_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/alu_bist_lfsr.sv
// bist_lfsr32: 32-bit Galois register used either as a free-running operand
// generator (advances two steps per update) or as a MISR (one step per
// update with the response word folded in).
module bist_lfsr32
  import alu_bist_pkg::*;
#(
  parameter logic [31:0] SEED    = 32'h0000_0001,
  parameter bit          DATA_EN = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] data,
  output logic [31:0] value,
  output logic [31:0] step1,
  output logic [31:0] step2
);

  logic [31:0] value_reg;
  logic [31:0] value_next;

  assign step1 = galois_step(value_reg);
  assign step2 = galois_step(step1);
  assign value = value_reg;

  generate
    if (DATA_EN) begin : g_misr
      assign value_next = step1 ^ data;
    end else begin : g_gen
      logic unused_data;
      assign unused_data = ^data;
      assign value_next  = step2;
    end
  endgenerate

  // Reload the seed on reset or load, otherwise advance when stepped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg <= SEED;
    end else if (load) begin
      value_reg <= SEED;
    end else if (step) begin
      value_reg <= value_next;
    end
  end

endmodule

// File: rtl/alu_bist_ctrl.sv
// alu_bist_ctrl: drives pseudo-random operand pairs into the ALU, sweeps the
// control codes for each pair, compacts {result, zero} into a MISR and checks
// the final signature against GOLDEN_SIG.
// Optional macro ALU_BIST_DIRECTED_EN adds four directed operand pairs that
// run before the random patterns.
module alu_bist_ctrl
  import alu_bist_pkg::*;
#(
  parameter int          NUM_PATTERNS = 64,
  parameter int          NUM_OPS      = 8,
  parameter logic [31:0] LFSR_SEED    = 32'h0000_0001,
  parameter logic [31:0] GOLDEN_SIG   = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [31:0]        alu_input1,
  output logic [31:0]        alu_input2,
  output logic [CNT_W-1:0]   alu_cnt,
  output logic [SHAMT_W-1:0] alu_shamt,
  input  logic [31:0]        alu_result,
  input  logic               alu_zero,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [31:0]        signature
);

  localparam logic [CNT_W-1:0] LAST_OP  = CNT_W'(NUM_OPS - 1);
  localparam logic [15:0]      LAST_PAT = 16'(NUM_PATTERNS - 1);

  bist_state_t state_reg;
  logic [15:0] pat_reg;
  logic        start_run;
  logic        opgen_step;
  logic        misr_step;
  logic [31:0] misr_data;
  logic [31:0] op_step1;
  logic [31:0] op_step2;
  logic [31:0] unused_op_value;
  logic [31:0] unused_misr_s1;
  logic [31:0] unused_misr_s2;

`ifdef ALU_BIST_DIRECTED_EN
  logic [2:0] dir_idx_reg;
  logic       dir_now;
  assign dir_now    = (dir_idx_reg != 3'(NUM_DIRECTED));
  assign opgen_step = (state_reg == LOAD) && !abort && !dir_now;
`else
  assign opgen_step = (state_reg == LOAD) && !abort;
`endif

  assign busy      = (state_reg != IDLE);
  assign start_run = (state_reg == IDLE) && start;
  assign misr_step = (state_reg == CAPTURE) && !abort;
  assign misr_data = alu_result ^ {31'b0, alu_zero};

  bist_lfsr32 #(.SEED(LFSR_SEED), .DATA_EN(1'b0)) u_opgen (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_run),
    .step  (opgen_step),
    .data  (32'h0),
    .value (unused_op_value),
    .step1 (op_step1),
    .step2 (op_step2)
  );

  bist_lfsr32 #(.SEED(32'h0), .DATA_EN(1'b1)) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (start_run),
    .step  (misr_step),
    .data  (misr_data),
    .value (signature),
    .step1 (unused_misr_s1),
    .step2 (unused_misr_s2)
  );

  // Run sequencing and registered ALU-facing outputs; abort overrides all.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      pat_reg    <= '0;
      alu_input1 <= '0;
      alu_input2 <= '0;
      alu_cnt    <= '0;
      alu_shamt  <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
`ifdef ALU_BIST_DIRECTED_EN
      dir_idx_reg <= '0;
`endif
    end else if (abort && state_reg != IDLE) begin
      state_reg <= IDLE;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            pat_reg   <= '0;
            alu_cnt   <= '0;
            done      <= 1'b0;
            pass      <= 1'b0;
            state_reg <= LOAD;
`ifdef ALU_BIST_DIRECTED_EN
            dir_idx_reg <= '0;
`endif
          end
        end
        LOAD: begin
`ifdef ALU_BIST_DIRECTED_EN
          if (dir_now) begin
            alu_input1 <= DIRECTED_PATS[dir_idx_reg[1:0]].op1;
            alu_input2 <= DIRECTED_PATS[dir_idx_reg[1:0]].op2;
            alu_shamt  <= DIRECTED_PATS[dir_idx_reg[1:0]].shamt;
          end else
`endif
          begin
            alu_input1 <= op_step1;
            alu_input2 <= op_step2;
            alu_shamt  <= op_step1[SHAMT_W-1:0];
          end
          alu_cnt   <= '0;
          state_reg <= CAPTURE;
        end
        CAPTURE: begin
          if (alu_cnt != LAST_OP) begin
            alu_cnt <= alu_cnt + 4'd1;
          end
`ifdef ALU_BIST_DIRECTED_EN
          else if (dir_now) begin
            dir_idx_reg <= dir_idx_reg + 3'd1;
            state_reg   <= LOAD;
          end
`endif
          else if (pat_reg != LAST_PAT) begin
            pat_reg   <= pat_reg + 16'd1;
            state_reg <= LOAD;
          end else begin
            state_reg <= CHECK;
          end
        end
        CHECK: begin
          pass      <= (signature == GOLDEN_SIG);
          done      <= 1'b1;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Scoreboard bench for alu_bist_ctrl with a behavioural ALU stand-in.
module tb_alu_bist_ctrl;

  localparam int          NP      = 2;
  localparam int          NO      = 8;
  localparam logic [31:0] SEED    = 32'h0000_0001;
  localparam int          RUN_LEN = NP * (NO + 1) + 1;

  function automatic logic [31:0] gal(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? 32'h0040_0007 : 32'h0);
  endfunction

  function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic [4:0] sh);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << sh;
      4'd6:    return a >> sh;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Whole-run signature: operand pairs are consecutive LFSR values, every op
  // of each pair is folded into the MISR in order.
  function automatic logic [31:0] model_sig(input bit flip);
    logic [31:0] l, m, a, b, r;
    l = SEED;
    m = 32'h0;
    for (int p = 0; p < NP; p++) begin
      a = gal(l);
      b = gal(a);
      l = b;
      for (int op = 0; op < NO; op++) begin
        r = alu_ref(a, b, 4'(op), a[4:0]);
        m = gal(m) ^ ((flip && op == 2) ? (r ^ 32'd1) : r) ^ {31'b0, r == 32'h0};
      end
    end
    return m;
  endfunction

  localparam logic [31:0] GOLD = model_sig(1'b0);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] alu_input1, alu_input2, alu_result, signature;
  logic [3:0]  alu_cnt;
  logic [4:0]  alu_shamt;
  logic        alu_zero, busy, done, pass;
  logic        fault_en = 1'b0;
  logic [31:0] true_r;

  always #5 clk = ~clk;

  alu_bist_ctrl #(
    .NUM_PATTERNS (NP),
    .NUM_OPS      (NO),
    .LFSR_SEED    (SEED),
    .GOLDEN_SIG   (GOLD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .alu_input1 (alu_input1),
    .alu_input2 (alu_input2),
    .alu_cnt    (alu_cnt),
    .alu_shamt  (alu_shamt),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .signature  (signature)
  );

  // Behavioural ALU; the fault flips result bit 0 for control code 2.
  always_comb begin
    true_r     = alu_ref(alu_input1, alu_input2, alu_cnt, alu_shamt);
    alu_zero   = (true_r == 32'h0);
    alu_result = true_r ^ {31'b0, fault_en && alu_cnt == 4'd2};
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] sig;
    bit          pass;
    int          done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   runs = 0;
  logic done_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every rising done is matched against the oldest expected run.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("signature", signature, e.sig);
          chk("pass", {31'b0, pass}, {31'b0, e.pass});
          runs++;
          $display("run %0d: sig=%h pass=%0d cycle=%0d", runs, signature, pass, cyc);
        end
      end
      done_prev = done;
    end
  end

  // Issue a start pulse; optionally raise abort alongside it and/or queue
  // the expected outcome of the run.
  task automatic launch(input bit flip, input bit expect_done, input bit with_abort);
    fault_en = flip;
    @(negedge clk);
    start = 1'b1;
    abort = with_abort;
    if (expect_done)
      exp_q.push_back('{sig: model_sig(flip), pass: (model_sig(flip) == GOLD), done_cyc: cyc + 1 + RUN_LEN});
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("run_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_first_operands();
    @(negedge clk);
    chk("op1", alu_input1, 32'd2);
    chk("op2", alu_input2, 32'd4);
    chk("shamt", {27'b0, alu_shamt}, 32'd2);
    chk("cnt0", {28'b0, alu_cnt}, 32'd0);
  endtask

  task automatic abort_now();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_pass", {31'b0, pass}, 32'd0);
  endtask

  initial begin
    int nz;
    int mode;
    int off;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Quiet after reset with no start.
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_sig", signature, 32'd0);
    chk("rst_op1", alu_input1, 32'd0);
    nz = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (|{alu_input1, alu_input2, alu_cnt, alu_shamt, busy, done, pass, signature}) nz++;
    end
    chk("idle_quiet", 32'(nz), 32'd0);

    // Clean run: operands, op sweep, pass.
    launch(1'b0, 1'b1, 1'b0);
    check_first_operands();
    for (int i = 1; i < NO; i++) begin
      @(negedge clk);
      chk("cnt_step", {28'b0, alu_cnt}, 32'(i));
    end
    wait_done();
    repeat (3) @(negedge clk);
    chk("done_held", {31'b0, done}, 32'd1);

    // Faulty ALU: signature must diverge.
    launch(1'b1, 1'b1, 1'b0);
    wait_done();
    chk("fault_sig_differs", {31'b0, signature != GOLD}, 32'd1);

    // Abort mid-run, then a clean rerun.
    launch(1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    abort_now();
    launch(1'b0, 1'b1, 1'b0);
    wait_done();

    // Start while busy is ignored.
    launch(1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Randomized runs: idle gaps with stray aborts, start+abort together,
    // random faults and random mid-run aborts.
    for (int it = 0; it < 10; it++) begin
      for (int g = $urandom_range(0, 4); g > 0; g--) begin
        abort = 1'($urandom_range(0, 1));
        @(negedge clk);
        abort = 1'b0;
      end
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        launch(1'b0, 1'b0, 1'b0);
        off = $urandom_range(0, 17);
        repeat (off) @(negedge clk);
        abort_now();
      end else begin
        launch(1'($urandom_range(0, 1)), 1'b1, mode == 1);
        wait_done();
      end
    end
    fault_en = 1'b0;

    // Asynchronous reset mid-CAPTURE.
    launch(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_outs", 32'(|{alu_input1, alu_input2, alu_cnt, alu_shamt, done, pass, signature}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    launch(1'b0, 1'b1, 1'b0);
    check_first_operands();
    wait_done();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_bist_ctrl.md
Name: alu_bist_ctrl

Overview:
- Synthesizable built-in self-test controller that drives the ALU operand/control interface and checks what comes back.
- Generates pseudo-random operand pairs and sweeps every ALU control code for each pair.
- Compacts each {ALU_result, Zero} response into a MISR signature and compares it with a golden value.
- Sits beside the ALU in the datapath; a test mux selects it in place of the decode-driven ALU inputs.

Parameters:
- NUM_PATTERNS, 64: number of operand pairs (1..65535).
- NUM_OPS, 8: ALU control codes swept per pair, 0..NUM_OPS-1 (1..16).
- LFSR_SEED, 32'h0000_0001: operand LFSR reset value; must be nonzero.
- GOLDEN_SIG, 32'h0000_0000: expected final MISR value; set per ALU build.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: single-cycle request to begin a run; sampled only in IDLE.
- abort, in, 1: terminates a run; returns to IDLE without done.
- alu_input1, out, 32: ALU operand 1.
- alu_input2, out, 32: ALU operand 2.
- alu_cnt, out, 4: ALU control code.
- alu_shamt, out, 5: ALU shift amount.
- alu_result, in, 32: ALU result.
- alu_zero, in, 1: ALU Zero flag.
- busy, out, 1: run in progress.
- done, out, 1: run completed; held until the next accepted start.
- pass, out, 1: final signature == GOLDEN_SIG; valid only while done=1.
- signature, out, 32: current MISR value.

Behaviour:
- Reset: all outputs and registers are 0, except the LFSR, which loads LFSR_SEED. State is IDLE. Reset takes effect immediately, including mid-run.
- LFSR (Galois, left shift): next = (L<<1) ^ (L[31] ? 32'h0040_0007 : 0).
- MISR update: next = ((M<<1) ^ (M[31] ? 32'h0040_0007 : 0)) ^ alu_result ^ {31'b0, alu_zero}.
- All ALU-facing outputs are registered.
- States:
  - IDLE: if start && !busy, clear the MISR, pattern counter and op counter; clear done and pass; load LFSR_SEED; go to LOAD.
  - LOAD (1 cycle): step the LFSR twice using combinational double-step logic. alu_input1 = value after the first step, alu_input2 = value after the second step. The LFSR register keeps the second value. alu_shamt = alu_input1[4:0]. alu_cnt = 0. Go to CAPTURE.
  - CAPTURE (1 cycle): update the MISR with the ALU outputs for the current alu_cnt.
    - If op < NUM_OPS-1: increment alu_cnt and stay in CAPTURE.
    - Else if pattern < NUM_PATTERNS-1: increment pattern and go to LOAD.
    - Else go to CHECK.
    - alu_cnt changes at the same edge as the capture, so each op is applied for exactly one cycle before sampling.
  - CHECK (1 cycle): pass <= (MISR == GOLDEN_SIG); done <= 1; go to IDLE.
- busy = (state != IDLE).
- Run length from start accepted to done=1 is NUM_PATTERNS*(NUM_OPS+1)+1 cycles. Defaults: 577.
- abort while busy: next cycle is IDLE with busy=0, done=0, pass=0. The MISR holds its partial value. abort in IDLE has no effect.
- abort has priority over every state transition.
- start while busy is ignored.
- start and abort together in IDLE: start wins.
- Counters do not wrap; the terminal compares above bound every run.
- alu_zero is only XORed into MISR bit 0; Zero is not compared separately.

Optional Feature:
- Macro: ALU_BIST_DIRECTED_EN.
- When defined, four directed operand pairs run before the random patterns, each followed by a full op sweep:
  - (0, 0, shamt 0)
  - (32'hFFFF_FFFF, 1, shamt 31)
  - (32'h7FFF_FFFF, 1, shamt 1)
  - (3, 3, shamt 1)
- Directed pairs do not advance the LFSR.
- Run length grows by 4*(NUM_OPS+1) cycles. GOLDEN_SIG must be regenerated for this configuration.
- When undefined, behaviour is exactly as in Behaviour; no directed ROM or extra state is synthesized.

Decomposition:
- Shared package alu_bist_pkg:
  - state enum {IDLE, LOAD, CAPTURE, CHECK}
  - polynomial constant BIST_POLY = 32'h0040_0007
  - ALU control-code width (4) and shamt width (5)
  - directed-pattern constant array
- One natural sub-module: bist_lfsr32.
  - Parametrized seed; step-by-2 output; clear/load input.
  - Instantiated twice: once as the operand generator (no data input) and once as the MISR (data input enabled).

Test Plan:
- Reset release, no start: all outputs 0, busy=0, signature=0 → remain so for 100 cycles.
- NUM_PATTERNS=2, NUM_OPS=8, seed 1, behavioural ALU model → first LOAD gives alu_input1=2, alu_input2=4, alu_shamt=2. alu_cnt steps 0..7. done rises exactly 19 cycles after start, pass=1 with GOLDEN_SIG taken from the bench model.
- Same setup, ALU model flips alu_result bit 0 when alu_cnt=2 → done after 19 cycles, pass=0, signature ≠ golden.
- Assert abort at cycle 7 of a run → busy=0 next cycle, done=0, pass=0. A subsequent start yields the same signature as an uninterrupted run.
- Pulse start again at cycle 5 of a run → ignored; done still at cycle 19 with an unchanged signature.
- Drop rst_n mid-CAPTURE → all outputs 0 asynchronously, state IDLE. The next start gives first operands 2 and 4 again.
